video_pattern_source: RTL and testbench
=======================================

Name: video_pattern_source

Overview:
- Avalon-ST video source that generates RGB565 test frames (solid colour, colour bars, checkerboard, gradient), framed with startofpacket/endofpacket.
- Feeds the sink side of the video processing IPs, replacing the camera/DMA stream during bring-up and verification.
- Configured and monitored through an Avalon-MM slave register bank.

Parameters:
- DEFAULT_WIDTH, 320, reset value of the frame width register (pixels).
- DEFAULT_HEIGHT, 240, reset value of the frame height register (lines).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- chipselect  in  1  MM chip select
- address  in  3  MM register address
- write  in  1  MM write strobe
- writedata  in  32  MM write data
- read  in  1  MM read strobe
- readdata  out  32  MM read data
- valid_out  out  1  ST data valid
- ready_in  in  1  ST ready from the downstream sink
- data_out  out  16  ST pixel, RGB565
- startofpacket_out  out  1  first pixel of frame
- endofpacket_out  out  1  last pixel of frame

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous, active-high.
- Outputs on reset: valid_out, data_out, startofpacket_out, endofpacket_out and readdata are all 0.
- Register reset values: CONTROL=0, SIZE={DEFAULT_HEIGHT,DEFAULT_WIDTH}, COLOR=0, frame count 0.
- Register map:
  - 0 CONTROL (RW): bit0 enable, bit1 single_shot, bits[3:2] pattern.
  - 1 SIZE (RW): [15:0] width, [31:16] height.
  - 2 COLOR (RW): [15:0] solid colour.
  - 3 STATUS: read gives bit0 busy, [31:16] frame_count. A write of any value clears frame_count.
  - 4-7: read 0, writes ignored.
- MM timing: register writes take effect on the next clk edge. Read latency is 0: readdata = selected register when chipselect&read, else 0.
- FSM IDLE:
  - valid_out=0.
  - If enable=1, width!=0 and height!=0: latch pattern, width, height and colour into shadow registers, set x=0, y=0, go to ACTIVE.
  - The first beat is valid on the cycle after the enable edge.
- FSM ACTIVE:
  - valid_out=1 with registered data/sop/eop for pixel (x,y).
  - Beat transfers when valid_out&ready_in. x/y and outputs advance only on a transfer.
  - While ready_in=0, valid_out and all outputs hold stable.
  - Back-to-back transfers sustain 1 pixel/clk.
- Frame markers:
  - startofpacket_out=1 only for x=0,y=0.
  - endofpacket_out=1 only for x=w-1,y=h-1.
  - For w=h=1, both are set on the same beat.
- Counter wrap: x wraps to 0 at w-1 and y then increments. The transfer of the eop beat completes the frame.
- Frame completion:
  - frame_count increments; it is 16 bits and wraps FFFF->0.
  - If single_shot=1: hardware clears enable and the FSM goes to IDLE, so valid_out=0 the next cycle.
  - Otherwise, if enable=1: re-latch shadows and emit the next frame's sop on the next cycle, with no gap.
  - Otherwise: go to IDLE.
- Mid-frame config: config writes never affect the frame in progress; shadow registers are used. Clearing enable mid-frame lets the current frame finish.
- Simultaneous events:
  - A CONTROL write in the completion cycle wins over the single_shot clear.
  - A STATUS write in the completion cycle leaves frame_count=0.
- busy=1 in ACTIVE.
- Patterns (x, y are 16-bit counters):
  - 0 solid: data = COLOR.
  - 1 bars: 8 bars of bar_w=w>>3 pixels each, using a bar counter, no divider. Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. The remainder pixels and the w<8 case go to the last bar that was reached (the index saturates at 7).
  - 2 checker: data = (x[4]^y[4]) ? FFFF : 0000.
  - 3 gradient: data = {x[4:0], y[5:0], 5'b00000}.

Decomposition:
- Package video_pkg holds:
  - register address constants;
  - CONTROL bit positions;
  - pattern codes;
  - the 8 bar colour constants;
  - the FSM state typedef (IDLE, ACTIVE).
- Sub-module video_pattern_regs holds the MM register bank, readdata mux, STATUS clear and single_shot clear. The top holds the FSM, counters and pixel generation.

Test Plan:
1. Reset -> all ST outputs 0, readdata of SIZE = 0x00F0_0140, CONTROL=0.
2. Set SIZE=0x0002_0004, COLOR=0xF800, CONTROL=0x3 with ready_in=1 -> 8 beats of F800, sop on beat 0, eop on beat 7, then valid_out=0, CONTROL reads 0x2, frame_count=1.
3. Same 4x2 frame with ready_in toggling pseudo-randomly -> no beat lost or duplicated, outputs stable while ready_in=0, 8 transfers total.
4. Pattern 1, SIZE=0x0001_0010, continuous enable -> per frame the pixels come in pairs FFFF,FFFF,FFE0,FFE0,...,0000,0000. The next frame's sop is on the cycle after the eop transfer.
5. Write SIZE=0x0001_0001 mid-frame of a 4x2 frame -> current frame still 8 beats; following frame is 1 beat with sop=eop=1.
6. Write STATUS in the same cycle as the eop transfer -> frame_count reads 0. SIZE width=0 with enable=1 -> valid_out stays 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the RGB565 test-pattern source: register map, control
// bit positions, pattern codes, bar colours and the stream FSM state type.
package video_pkg;

    localparam logic [2:0] ADDR_CONTROL = 3'd0;
    localparam logic [2:0] ADDR_SIZE    = 3'd1;
    localparam logic [2:0] ADDR_COLOR   = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_SINGLE = 1;
    localparam int CTRL_PAT_LO = 2;

    localparam logic [1:0] PAT_SOLID    = 2'd0;
    localparam logic [1:0] PAT_BARS     = 2'd1;
    localparam logic [1:0] PAT_CHECKER  = 2'd2;
    localparam logic [1:0] PAT_GRADIENT = 2'd3;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] pixel_value(input logic [1:0]  pat,
                                                input logic [15:0] color,
                                                input logic [15:0] x,
                                                input logic [15:0] y,
                                                input logic [2:0]  bar_idx);
        case (pat)
            PAT_SOLID:   return color;
            PAT_BARS:    return bar_color(bar_idx);
            PAT_CHECKER: return (x[4] ^ y[4]) ? 16'hFFFF : 16'h0000;
            default:     return {x[4:0], y[5:0], 5'b00000};
        endcase
    endfunction

endpackage

// File: rtl/video_pattern_regs.sv
// Avalon-MM register bank for the pattern source: CONTROL/SIZE/COLOR/STATUS,
// zero-latency read mux, frame counter and the single-shot enable clear.
module video_pattern_regs
    import video_pkg::*;
#(
    parameter int DEFAULT_WIDTH  = 320,
    parameter int DEFAULT_HEIGHT = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        busy,
    input  logic        frame_done,
    output logic        enable,
    output logic        single_shot,
    output logic [1:0]  pattern,
    output logic [15:0] width,
    output logic [15:0] height,
    output logic [15:0] color
);

    localparam logic [15:0] RST_WIDTH  = 16'(DEFAULT_WIDTH);
    localparam logic [15:0] RST_HEIGHT = 16'(DEFAULT_HEIGHT);

    logic [3:0]  control;
    logic [15:0] frame_count;
    logic        wr_en;

    assign wr_en       = chipselect & write;
    assign enable      = control[CTRL_ENABLE];
    assign single_shot = control[CTRL_SINGLE];
    assign pattern     = control[CTRL_PAT_LO +: 2];

    always_ff @(posedge clk) begin
        if (reset) begin
            control     <= '0;
            width       <= RST_WIDTH;
            height      <= RST_HEIGHT;
            color       <= '0;
            frame_count <= '0;
        end else begin
            // A host write to CONTROL takes priority over the hardware clear.
            if (wr_en && address == ADDR_CONTROL)
                control <= writedata[3:0];
            else if (frame_done && control[CTRL_SINGLE])
                control[CTRL_ENABLE] <= 1'b0;

            if (wr_en && address == ADDR_SIZE) begin
                width  <= writedata[15:0];
                height <= writedata[31:16];
            end

            if (wr_en && address == ADDR_COLOR)
                color <= writedata[15:0];

            if (wr_en && address == ADDR_STATUS)
                frame_count <= '0;
            else if (frame_done)
                frame_count <= frame_count + 16'd1;
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect && read) begin
            case (address)
                ADDR_CONTROL: readdata = {28'd0, control};
                ADDR_SIZE:    readdata = {height, width};
                ADDR_COLOR:   readdata = {16'd0, color};
                ADDR_STATUS:  readdata = {frame_count, 15'd0, busy};
                default:      readdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/video_pattern_source.sv
// Avalon-ST RGB565 test-frame generator: shadowed frame geometry, x/y and bar
// counters, and registered pixel/sop/eop that advance only on a transfer.
module video_pattern_source
    import video_pkg::*;
#(
    parameter int DEFAULT_WIDTH  = 320,
    parameter int DEFAULT_HEIGHT = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [15:0] data_out,
    output logic        startofpacket_out,
    output logic        endofpacket_out
);

    logic        enable, single_shot;
    logic [1:0]  pattern;
    logic [15:0] width, height, color;

    state_t      state;
    logic [1:0]  sh_pat;
    logic [15:0] sh_w, sh_h, sh_color;
    logic [15:0] x, y, bar_cnt;
    logic [2:0]  bar_idx;

    logic        transfer, frame_done, start_ok, load;
    logic        x_last;
    logic [15:0] nx, ny, n_bar_cnt, bar_w;
    logic [2:0]  n_bar_idx;

    video_pattern_regs #(
        .DEFAULT_WIDTH (DEFAULT_WIDTH),
        .DEFAULT_HEIGHT(DEFAULT_HEIGHT)
    ) u_regs (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .address    (address),
        .write      (write),
        .writedata  (writedata),
        .read       (read),
        .readdata   (readdata),
        .busy       (state == ST_ACTIVE),
        .frame_done (frame_done),
        .enable     (enable),
        .single_shot(single_shot),
        .pattern    (pattern),
        .width      (width),
        .height     (height),
        .color      (color)
    );

    assign transfer   = valid_out & ready_in;
    assign frame_done = transfer & endofpacket_out;
    assign start_ok   = enable && (width != 16'd0) && (height != 16'd0);
    // Start from idle, or chain straight into the next frame with no gap.
    assign load       = (state == ST_IDLE && start_ok) ||
                        (state == ST_ACTIVE && frame_done && !single_shot && start_ok);

    always_comb begin
        bar_w     = sh_w >> 3;
        x_last    = (x == sh_w - 16'd1);
        nx        = x_last ? 16'd0 : x + 16'd1;
        ny        = x_last ? y + 16'd1 : y;
        n_bar_idx = bar_idx;
        n_bar_cnt = bar_cnt + 16'd1;
        if (x_last) begin
            n_bar_idx = 3'd0;
            n_bar_cnt = 16'd0;
        end else if (bar_w != 16'd0 && bar_cnt == bar_w - 16'd1 && bar_idx != 3'd7) begin
            n_bar_idx = bar_idx + 3'd1;
            n_bar_cnt = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            valid_out         <= 1'b0;
            data_out          <= '0;
            startofpacket_out <= 1'b0;
            endofpacket_out   <= 1'b0;
            sh_pat            <= '0;
            sh_w              <= '0;
            sh_h              <= '0;
            sh_color          <= '0;
            x                 <= '0;
            y                 <= '0;
            bar_idx           <= '0;
            bar_cnt           <= '0;
        end else if (load) begin
            state             <= ST_ACTIVE;
            sh_pat            <= pattern;
            sh_w              <= width;
            sh_h              <= height;
            sh_color          <= color;
            x                 <= '0;
            y                 <= '0;
            bar_idx           <= '0;
            bar_cnt           <= '0;
            valid_out         <= 1'b1;
            data_out          <= pixel_value(pattern, color, 16'd0, 16'd0, 3'd0);
            startofpacket_out <= 1'b1;
            endofpacket_out   <= (width == 16'd1) && (height == 16'd1);
        end else if (state == ST_ACTIVE && transfer) begin
            if (endofpacket_out) begin
                state             <= ST_IDLE;
                valid_out         <= 1'b0;
                data_out          <= '0;
                startofpacket_out <= 1'b0;
                endofpacket_out   <= 1'b0;
            end else begin
                x                 <= nx;
                y                 <= ny;
                bar_idx           <= n_bar_idx;
                bar_cnt           <= n_bar_cnt;
                data_out          <= pixel_value(sh_pat, sh_color, nx, ny, n_bar_idx);
                startofpacket_out <= 1'b0;
                endofpacket_out   <= (nx == sh_w - 16'd1) && (ny == sh_h - 16'd1);
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_source.sv
// Self-checking bench for video_pattern_source: register vector table plus
// directed frame sequences with an independent pixel model.
module tb_video_pattern_source;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect, write, read, ready_in;
    logic [2:0]  address;
    logic [31:0] writedata, readdata;
    logic        valid_out, startofpacket_out, endofpacket_out;
    logic [15:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] cap_data[$];
    bit          cap_sop[$];
    bit          cap_eop[$];
    int          cap_cyc[$];

    logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } mm_vec_t;

    mm_vec_t vecs[$];

    video_pattern_source dut (
        .clk              (clk),
        .reset            (reset),
        .chipselect       (chipselect),
        .address          (address),
        .write            (write),
        .writedata        (writedata),
        .read             (read),
        .readdata         (readdata),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .data_out         (data_out),
        .startofpacket_out(startofpacket_out),
        .endofpacket_out  (endofpacket_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mm_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic mm_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        #1 d = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    function automatic logic [15:0] model_pix(input int pat, input int w, input int x,
                                              input int y, input logic [15:0] col);
        logic [15:0] xv, yv;
        int bw, idx;
        xv = 16'(x);
        yv = 16'(y);
        bw = w / 8;
        idx = (bw == 0) ? 0 : x / bw;
        if (idx > 7) idx = 7;
        case (pat)
            0:       return col;
            1:       return bar_tab[idx];
            2:       return (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 16'hFFFF : 16'h0000;
            default: return {xv[4:0], yv[5:0], 5'b00000};
        endcase
    endfunction

    // Capture transfers; trig_mode 1 issues an MM write at cycle trig_cyc,
    // trig_mode 2 issues it in the same cycle as the eop transfer.
    task automatic collect(input int nbeats, input bit rnd, input int trig_mode,
                           input int trig_cyc, input logic [2:0] ta, input logic [31:0] td);
        int cyc = 0;
        int mode = trig_mode;
        bit prev_stall = 0;
        logic [15:0] pd = '0;
        bit ps = 0, pe = 0;
        cap_data.delete(); cap_sop.delete(); cap_eop.delete(); cap_cyc.delete();
        while (cap_data.size() < nbeats && cyc < 400) begin
            @(negedge clk);
            chipselect = 1'b0; write = 1'b0;
            ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) begin
                check("stall_valid", {31'd0, valid_out}, 32'd1);
                check("stall_data", {16'd0, data_out}, {16'd0, pd});
                check("stall_sop_eop", {30'd0, startofpacket_out, endofpacket_out}, {30'd0, ps, pe});
            end
            if ((mode == 1 && cyc == trig_cyc) ||
                (mode == 2 && valid_out && ready_in && endofpacket_out)) begin
                chipselect = 1'b1; write = 1'b1; address = ta; writedata = td;
                mode = 0;
            end
            if (valid_out && ready_in) begin
                cap_data.push_back(data_out);
                cap_sop.push_back(startofpacket_out);
                cap_eop.push_back(endofpacket_out);
                cap_cyc.push_back(cyc);
            end
            prev_stall = valid_out && !ready_in;
            pd = data_out; ps = startofpacket_out; pe = endofpacket_out;
            cyc++;
        end
        if (cap_data.size() < nbeats)
            check("collect_timeout", cap_data.size(), nbeats);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        ready_in = 1'b1;
        #1;
    endtask

    task automatic run_frame(input string tag, input logic [31:0] ctrl, input logic [31:0] size,
                             input logic [15:0] col, input bit rnd);
        int w = int'(size[15:0]);
        int h = int'(size[31:16]);
        int n = w * h;
        mm_write(3'd1, size);
        mm_write(3'd2, {16'd0, col});
        mm_write(3'd0, ctrl);
        collect(n, rnd, 0, 0, 3'd0, 32'd0);
        if (ctrl[1]) check({tag, "_idle_after"}, {31'd0, valid_out}, 32'd0);
        for (int i = 0; i < n && i < cap_data.size(); i++) begin
            check($sformatf("%s_pix%0d", tag, i), {16'd0, cap_data[i]},
                  {16'd0, model_pix(int'(ctrl[3:2]), w, i % w, i / w, col)});
            check($sformatf("%s_sop_eop%0d", tag, i), {30'd0, cap_sop[i], cap_eop[i]},
                  {30'd0, i == 0, i == n - 1});
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60 && valid_out; i++) begin
            @(negedge clk);
            #1;
        end
        check(tag, {31'd0, valid_out}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        bit stayed_low;

        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; ready_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_st_outputs", {valid_out, startofpacket_out, endofpacket_out, data_out}, 32'd0);
        chipselect = 1'b1; address = 3'd1;
        #1 check("rst_readdata_noread", readdata, 32'd0);
        chipselect = 1'b0;

        vecs.push_back('{0, 3'd0, 32'd0, 32'h0000_0000});
        vecs.push_back('{0, 3'd1, 32'd0, 32'h00F0_0140});
        vecs.push_back('{0, 3'd2, 32'd0, 32'h0000_0000});
        vecs.push_back('{0, 3'd3, 32'd0, 32'h0000_0000});
        vecs.push_back('{0, 3'd4, 32'd0, 32'h0000_0000});
        vecs.push_back('{1, 3'd2, 32'hABCD_1234, 32'd0});
        vecs.push_back('{0, 3'd2, 32'd0, 32'h0000_1234});
        vecs.push_back('{1, 3'd5, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{0, 3'd5, 32'd0, 32'h0000_0000});
        vecs.push_back('{1, 3'd1, 32'h0002_0004, 32'd0});
        vecs.push_back('{0, 3'd1, 32'd0, 32'h0002_0004});
        vecs.push_back('{1, 3'd0, 32'h0000_000C, 32'd0});
        vecs.push_back('{0, 3'd0, 32'd0, 32'h0000_000C});
        vecs.push_back('{1, 3'd0, 32'h0000_0000, 32'd0});
        vecs.push_back('{0, 3'd0, 32'd0, 32'h0000_0000});
        foreach (vecs[i]) begin
            if (vecs[i].wr) mm_write(vecs[i].addr, vecs[i].data);
            else begin
                mm_read(vecs[i].addr, rd);
                check($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
            end
        end
        check("no_stream_while_disabled", {31'd0, valid_out}, 32'd0);

        // Single-shot 4x2 solid frame at full rate.
        run_frame("solid", 32'h3, 32'h0002_0004, 16'hF800, 1'b0);
        mm_read(3'd0, rd); check("ss_ctrl_cleared", rd, 32'h2);
        mm_read(3'd3, rd); check("ss_frame_count", rd, 32'h0001_0000);

        // Gradient 4x2 with random backpressure; each beat is distinct.
        run_frame("grad_bp", 32'hF, 32'h0002_0004, 16'h0000, 1'b1);
        run_frame("bars20", 32'h7, 32'h0001_0014, 16'h0000, 1'b0);
        run_frame("checker", 32'hB, 32'h0002_0028, 16'h0000, 1'b0);
        run_frame("one_px", 32'h3, 32'h0001_0001, 16'h1234, 1'b0);

        // Continuous bars, 16x1: back-to-back frames with no gap.
        mm_write(3'd1, 32'h0001_0010);
        mm_write(3'd0, 32'h5);
        collect(32, 1'b0, 0, 0, 3'd0, 32'd0);
        for (int i = 0; i < 32 && i < cap_data.size(); i++) begin
            check($sformatf("bars_cont%0d", i), {16'd0, cap_data[i]}, {16'd0, bar_tab[(i % 16) / 2]});
            check($sformatf("bars_cont_se%0d", i), {30'd0, cap_sop[i], cap_eop[i]},
                  {30'd0, (i % 16) == 0, (i % 16) == 15});
        end
        if (cap_cyc.size() == 32) check("no_gap", cap_cyc[16], cap_cyc[15] + 1);
        mm_write(3'd0, 32'h0);
        wait_idle("bars_stop");

        // SIZE change mid-frame only affects the following frame.
        mm_write(3'd1, 32'h0002_0004);
        mm_write(3'd2, 32'h0000_07E0);
        mm_write(3'd0, 32'h1);
        collect(10, 1'b0, 1, 3, 3'd1, 32'h0001_0001);
        for (int i = 0; i < 10 && i < cap_data.size(); i++) begin
            check($sformatf("midcfg_data%0d", i), {16'd0, cap_data[i]}, 32'h0000_07E0);
            check($sformatf("midcfg_se%0d", i), {30'd0, cap_sop[i], cap_eop[i]},
                  {30'd0, i == 0 || i >= 8, i >= 7});
        end
        mm_write(3'd0, 32'h0);
        wait_idle("midcfg_stop");

        // STATUS write coinciding with the eop transfer leaves count at 0.
        mm_write(3'd1, 32'h0002_0004);
        mm_write(3'd0, 32'h3);
        collect(8, 1'b0, 2, 0, 3'd3, 32'h0);
        mm_read(3'd3, rd); check("status_clear_at_eop", rd, 32'h0);

        // Zero width with enable set must never start a frame.
        mm_write(3'd1, 32'h0002_0000);
        mm_write(3'd0, 32'h1);
        stayed_low = 1;
        repeat (10) begin
            @(negedge clk);
            #1 if (valid_out) stayed_low = 0;
        end
        check("zero_width_no_valid", {31'd0, stayed_low}, 32'd1);
        mm_read(3'd3, rd); check("zero_width_not_busy", rd, 32'h0);
        mm_write(3'd0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
